pipe_csel_adder: RTL and testbench

PIPE_CSEL_ADDER -- requirements
Module: pipe_csel_adder

---
 rtl/pipe_csel_pkg.sv | 18 +
 rtl/pipe_csel_adder_if.sv | 31 +++
 rtl/csel_block.sv | 19 +
 rtl/pipe_csel_adder.sv | 121 ++++++++++++
 tb/tb_pipe_csel_adder.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_csel_pkg.sv
// Shared constants and mode encoding for the pipelined carry-select adder.
// Also holds the stage-count helper so every user derives it the same way.
package pipe_csel_pkg;

    localparam int DEF_WIDTH        = 32;
    localparam int DEF_BLK          = 4;
    localparam int DEF_BLKS_PER_STG = 4;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    function automatic int calc_nstg(input int width, input int blk, input int blks_per_stg);
        return width / (blk * blks_per_stg);
    endfunction

endpackage

// File: rtl/pipe_csel_adder_if.sv
// Operand/result stream of the pipelined adder.
// Handshake: a beat moves on a rising edge only when valid and ready are both 1;
// valid must not depend on ready, and payload is held while valid=1 and ready=0.
interface pipe_csel_adder_if
    import pipe_csel_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/csel_block.sv
// One carry-select slice: both carry-in outcomes are precomputed and the
// real incoming carry only drives the final mux.
module csel_block #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] s,
    output logic           co
);
    logic [BLK:0] w_r0;
    logic [BLK:0] w_r1;

    assign w_r0    = {1'b0, a} + {1'b0, b};
    assign w_r1    = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};
    assign {co, s} = cin ? w_r1 : w_r0;

endmodule

// File: rtl/pipe_csel_adder.sv
// Pipelined carry-select adder/subtractor: each stage resolves BLKS_PER_STG
// select blocks and hands its carry plus the untouched upper operands on.
module pipe_csel_adder
    import pipe_csel_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int BLK          = DEF_BLK,
    parameter int BLKS_PER_STG = DEF_BLKS_PER_STG
) (
    input  logic             clk,
    input  logic             rst,
    pipe_csel_adder_if.slave bus
);
    localparam int NBLK = WIDTH / BLK;
    localparam int NSTG = calc_nstg(WIDTH, BLK, BLKS_PER_STG);
    localparam int SW   = BLK * BLKS_PER_STG;

    if ((BLK < 1) || (WIDTH % BLK != 0)) begin : g_bad_blk
        $error("pipe_csel_adder: WIDTH must be a positive multiple of BLK");
    end
    if ((BLKS_PER_STG < 1) || (NBLK % BLKS_PER_STG != 0) || (NSTG < 1)) begin : g_bad_stg
        $error("pipe_csel_adder: WIDTH/BLK must be a positive multiple of BLKS_PER_STG");
    end

    // Stage inputs: index 0 comes from the bus, index k from stage k-1 registers.
    logic [WIDTH-1:0] w_a   [NSTG];
    logic [WIDTH-1:0] w_b   [NSTG];
    logic [WIDTH-1:0] w_s   [NSTG];
    logic             w_c   [NSTG];
    logic             w_v   [NSTG];
    logic [WIDTH-1:0] w_sn  [NSTG];

    logic [WIDTH-1:0] r_a   [NSTG];
    logic [WIDTH-1:0] r_b   [NSTG];
    logic [WIDTH-1:0] r_sum [NSTG];
    logic             r_c   [NSTG];
    logic             r_vld [NSTG];
    logic             r_ovf;

    logic [NBLK-1:0]  w_bci;
    logic [NBLK-1:0]  w_bco;
    logic [WIDTH-1:0] w_bs;
    logic             w_msb_ci;
    logic             w_ovf;
    logic             w_adv;
    logic             w_is_sub;

    assign w_is_sub = (mode_e'(bus.sub) == MODE_SUB);
    assign w_adv    = !r_vld[NSTG-1] || bus.out_ready;

    always_comb begin
        w_a[0] = bus.a;
        w_b[0] = w_is_sub ? ~bus.b : bus.b;
        w_c[0] = w_is_sub ? 1'b1 : bus.cin;
        w_s[0] = '0;
        w_v[0] = bus.in_valid;
        for (int k = 1; k < NSTG; k++) begin
            w_a[k] = r_a[k-1];
            w_b[k] = r_b[k-1];
            w_c[k] = r_c[k-1];
            w_s[k] = r_sum[k-1];
            w_v[k] = r_vld[k-1];
        end
    end

    // Block carry chain restarts at each stage boundary from the registered carry.
    for (genvar g = 0; g < NBLK; g++) begin : g_blk
        localparam int STG = g / BLKS_PER_STG;
        if (g % BLKS_PER_STG == 0) begin : g_first
            assign w_bci[g] = w_c[STG];
        end else begin : g_chain
            assign w_bci[g] = w_bco[g-1];
        end
        csel_block #(.BLK(BLK)) u_blk (
            .a   (w_a[STG][g*BLK +: BLK]),
            .b   (w_b[STG][g*BLK +: BLK]),
            .cin (w_bci[g]),
            .s   (w_bs[g*BLK +: BLK]),
            .co  (w_bco[g])
        );
    end

    always_comb begin
        for (int k = 0; k < NSTG; k++) begin
            w_sn[k]             = w_s[k];
            w_sn[k][k*SW +: SW] = w_bs[k*SW +: SW];
        end
        // Carry into the MSB recovered from the MSB sum bit of the final stage.
        w_msb_ci = w_a[NSTG-1][WIDTH-1] ^ w_b[NSTG-1][WIDTH-1] ^ w_bs[WIDTH-1];
        w_ovf    = w_msb_ci ^ w_bco[NBLK-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSTG; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
                r_c[k]   <= 1'b0;
                r_vld[k] <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < NSTG; k++) begin
                r_a[k]   <= w_a[k];
                r_b[k]   <= w_b[k];
                r_sum[k] <= w_sn[k];
                r_c[k]   <= w_bco[(k+1)*BLKS_PER_STG-1];
                r_vld[k] <= w_v[k];
            end
            r_ovf <= w_ovf;
        end
    end

    assign bus.in_ready  = w_adv && !rst;
    assign bus.out_valid = r_vld[NSTG-1];
    assign bus.sum       = r_sum[NSTG-1];
    assign bus.cout      = r_c[NSTG-1];
    assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_pipe_csel_adder.sv
// Bench for pipe_csel_adder: directed vectors and corner sequences on a default
// instance, plus randomized streams on three parameter sets against an arithmetic model.
module tb_pipe_csel_adder;
    import pipe_csel_pkg::*;

    localparam int LIMIT = 40000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done   = 0;

    pipe_csel_adder_if #(.WIDTH(32)) dut_if ();

    pipe_csel_adder #(.WIDTH(32), .BLK(4), .BLKS_PER_STG(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub);
        dut_if.in_valid = v;
        dut_if.a        = a;
        dut_if.b        = b;
        dut_if.cin      = cin;
        dut_if.sub      = sub;
    endtask

    initial begin
        int got;
        int ptr;
        int n_val;
        int first_idx;

        vecs[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[1]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[2]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[3]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0};
        vecs[4]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[5]  = '{32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0};
        vecs[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[7]  = '{32'h00000007, 32'h00000007, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[8]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[9]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0};
        vecs[10] = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[11] = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1};

        rst = 1'b1;
        drive(1'b1, 32'h1, 32'h1, 1'b0, 1'b0);
        dut_if.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", 66'(dut_if.in_ready), 66'd0);
        chk("rst_out_valid", 66'(dut_if.out_valid), 66'd0);
        chk("rst_outputs", {dut_if.cout, dut_if.ovf, dut_if.sum}, 66'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 66'(dut_if.in_ready), 66'd1);

        // Single beats: out_valid must be low after one edge and carry the result after two.
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            @(negedge clk);
            chk($sformatf("vec%0d_lat1_valid", i), 66'(dut_if.out_valid), 66'd0);
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 66'(dut_if.out_valid), 66'd1);
            chk($sformatf("vec%0d_result", i), {dut_if.cout, dut_if.ovf, dut_if.sum},
                {vecs[i].cout, vecs[i].ovf, vecs[i].sum});
        end

        // Back-to-back beats (k, k+1) into a stalled output, then release.
        @(negedge clk);
        got = 0;
        ptr = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (cyc >= 2 && cyc < 4)
                chk($sformatf("b2b_hold_c%0d", cyc),
                    {dut_if.out_valid, dut_if.in_ready, dut_if.sum}, {1'b1, 1'b0, 32'd1});
            dut_if.out_ready = (cyc >= 4);
            if (ptr < 4) drive(1'b1, 32'(ptr), 32'(ptr + 1), 1'b0, 1'b0);
            else         drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            #1;
            if (dut_if.out_valid && dut_if.out_ready) begin
                chk($sformatf("b2b_order%0d", got), 66'(dut_if.sum), 66'(2 * got + 1));
                got++;
            end
            if (dut_if.in_valid && dut_if.in_ready) ptr++;
        end
        chk("b2b_count", 66'(got), 66'd4);

        // Reset pulse with two beats in flight; only the post-reset beat may emerge.
        @(negedge clk);
        dut_if.out_ready = 1'b1;
        drive(1'b1, 32'd100, 32'd23, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'd200, 32'd1, 1'b0, 1'b0);
        @(negedge clk);
        dut_if.out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("rstpulse_out_valid", 66'(dut_if.out_valid), 66'd0);
        chk("rstpulse_sum", {dut_if.cout, dut_if.ovf, dut_if.sum}, 66'd0);
        rst = 1'b0;
        dut_if.out_ready = 1'b1;
        drive(1'b1, 32'd10, 32'd3, 1'b0, 1'b1);
        #1;
        chk("rstpulse_in_ready", 66'(dut_if.in_ready), 66'd1);
        n_val = 0;
        first_idx = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            if (dut_if.out_valid) begin
                if (first_idx < 0) first_idx = i;
                n_val++;
                chk("rstpulse_result", {dut_if.cout, dut_if.ovf, dut_if.sum},
                    {1'b1, 1'b0, 32'd7});
            end
        end
        chk("rstpulse_count", 66'(n_val), 66'd1);
        chk("rstpulse_latency", 66'(first_idx), 66'd1);

        for (int i = 0; i < 2 * LIMIT && n_done < 3; i++) @(posedge clk);
        n_checks++;
        if (n_done < 3) begin
            n_errors++;
            $display("FAIL random_done: got %0d finished streams expected 3", n_done);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Randomized streams on three parameter sets, each with its own scoreboard.
    for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
        localparam int W     = (gi == 0) ? 32 : (gi == 1) ? 16 : 64;
        localparam int BK    = (gi == 2) ? 8 : 4;
        localparam int BPS   = (gi == 0) ? 4 : (gi == 1) ? 1 : 2;
        localparam int NS    = W / (BK * BPS);
        localparam int NBEAT = 10000;

        logic rst_r;
        logic [W+1:0] exp_q [$];

        pipe_csel_adder_if #(.WIDTH(W)) bus ();

        pipe_csel_adder #(.WIDTH(W), .BLK(BK), .BLKS_PER_STG(BPS)) u_dut (
            .clk (clk),
            .rst (rst_r),
            .bus (bus)
        );

        // Returns {cout, ovf, sum} from plain integer arithmetic.
        function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                                   input logic c, input logic s);
            logic [W-1:0] r;
            logic         co;
            logic         ov;
            if (s) begin
                r  = a - b;
                co = (a >= b);
                ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end else begin
                {co, r} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
                ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            return {co, ov, r};
        endfunction

        initial begin
            logic [63:0]  ra;
            logic [63:0]  rb;
            logic [W+1:0] act;
            logic [W+1:0] held;
            logic [W+1:0] exp_v;
            bit           stalled;
            bit           full_rate;
            int           sent;
            int           cyc;
            int           thr_cyc;

            rst_r         = 1'b1;
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b0;
            bus.a         = '0;
            bus.b         = '0;
            bus.cin       = 1'b0;
            bus.sub       = 1'b0;
            repeat (2) @(negedge clk);
            rst_r   = 1'b0;
            sent    = 0;
            cyc     = 0;
            thr_cyc = 0;
            stalled = 1'b0;
            held    = '0;

            while ((sent < NBEAT || exp_q.size() > 0) && cyc < LIMIT) begin
                @(negedge clk);
                act = {bus.cout, bus.ovf, bus.sum};
                if (stalled) begin
                    n_checks++;
                    if ({bus.out_valid, act} !== {1'b1, held}) begin
                        n_errors++;
                        $display("FAIL cfg%0d hold: got %b/%h expected 1/%h", gi,
                                 bus.out_valid, act, held);
                    end
                end
                full_rate = (sent >= NBEAT - 200) && (sent < NBEAT);
                if (full_rate) begin
                    bus.in_valid  = 1'b1;
                    bus.out_ready = 1'b1;
                end else begin
                    bus.in_valid  = (sent < NBEAT) && ($urandom_range(0, 3) != 0);
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                ra      = {$urandom, $urandom};
                rb      = {$urandom, $urandom};
                bus.a   = ra[W-1:0];
                bus.b   = rb[W-1:0];
                bus.cin = 1'($urandom_range(0, 1));
                bus.sub = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 7))
                    0: bus.a = '1;
                    1: bus.b = '1;
                    2: bus.b = bus.a;
                    3: bus.a = {1'b0, {(W-1){1'b1}}};
                    default: ;
                endcase
                #1;
                if (full_rate) begin
                    n_checks++;
                    if (bus.in_ready !== 1'b1) begin
                        n_errors++;
                        $display("FAIL cfg%0d thr_in_ready: got %b expected 1", gi, bus.in_ready);
                    end
                    if (thr_cyc >= NS) begin
                        n_checks++;
                        if (bus.out_valid !== 1'b1) begin
                            n_errors++;
                            $display("FAIL cfg%0d thr_out_valid: got %b expected 1", gi,
                                     bus.out_valid);
                        end
                    end
                    thr_cyc++;
                end
                if (bus.out_valid && bus.out_ready) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL cfg%0d extra_result: got %h expected none", gi, act);
                    end else begin
                        exp_v = exp_q.pop_front();
                        if (act !== exp_v) begin
                            n_errors++;
                            $display("FAIL cfg%0d result: got %h expected %h", gi, act, exp_v);
                        end
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back(ref_model(bus.a, bus.b, bus.cin, bus.sub));
                    sent++;
                end
                stalled = bus.out_valid && !bus.out_ready;
                held    = act;
                cyc++;
            end

            n_checks++;
            if (sent != NBEAT || exp_q.size() != 0) begin
                n_errors++;
                $display("FAIL cfg%0d drain: got sent=%0d pending=%0d expected sent=%0d pending=0",
                         gi, sent, exp_q.size(), NBEAT);
            end
            bus.in_valid = 1'b0;
            n_done++;
        end
    end

endmodule
